// File: rtl/serial_word_source_if.sv
// Parallel word handshake into serial_word_source.
// A word moves on a rising edge where load && ready; ready never depends on load.
interface serial_word_source_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] din;
  logic             load;
  logic             ready;

  modport master (output din, output load, input ready);
  modport slave  (input din, input load, output ready);
endinterface

// File: rtl/serial_word_source.sv
// Serialises parallel words onto a single bit line for the sequence detectors,
// with a one-word holding register so consecutive words stream without gaps.
module serial_word_source #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_BIT  = 1'b0
) (
  input  logic                CLK,
  input  logic                CLR,
  serial_word_source_if.slave bus,
  output logic                x,
  output logic                busy,
  output logic                last,
  output logic                dbg_state_o
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             hold_v_q, hold_v_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             x_q, x_d;
  logic             busy_q, busy_d;
  logic             last_q, last_d;
  logic             accept;

  function automatic logic head_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
  endfunction

  assign bus.ready   = !hold_v_q;
  assign accept      = bus.load && !hold_v_q;
  assign x           = x_q;
  assign busy        = busy_q;
  assign last        = last_q;
  assign dbg_state_o = (state_q == ST_SHIFT);

  always_comb begin
    state_d  = state_q;
    sh_d     = sh_q;
    hold_d   = hold_q;
    hold_v_d = hold_v_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          sh_d    = bus.din;
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (cnt_q == CNT_LAST) begin
          // Word boundary: a held word takes priority; ready is low here anyway.
          cnt_d = '0;
          if (hold_v_q) begin
            sh_d     = hold_q;
            hold_v_d = 1'b0;
          end else if (accept) begin
            sh_d = bus.din;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          sh_d  = advance(sh_q);
          cnt_d = cnt_q + CW'(1);
          if (accept) begin
            hold_d   = bus.din;
            hold_v_d = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d == ST_SHIFT);
    x_d    = busy_d ? head_bit(sh_d) : IDLE_BIT;
    last_d = busy_d && (cnt_d == CNT_LAST);
  end

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      state_q  <= ST_IDLE;
      sh_q     <= '0;
      hold_q   <= '0;
      hold_v_q <= 1'b0;
      cnt_q    <= '0;
      x_q      <= IDLE_BIT;
      busy_q   <= 1'b0;
      last_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sh_q     <= sh_d;
      hold_q   <= hold_d;
      hold_v_q <= hold_v_d;
      cnt_q    <= cnt_d;
      x_q      <= x_d;
      busy_q   <= busy_d;
      last_q   <= last_d;
    end
  end

endmodule

// File: tb/tb_serial_word_source.sv
// Bench for serial_word_source: an MSB-first/idle-0 and an LSB-first/idle-1
// instance share one sender; a bit-queue reference model predicts x, last, busy, ready.
module tb_serial_word_source;

  localparam int W = 8;

  logic clk = 1'b0;
  logic clr = 1'b1;
  always #5 clk = ~clk;

  logic [W-1:0] din_r  = '0;
  logic         load_r = 1'b0;

  serial_word_source_if #(.WIDTH(W)) bus_m ();
  serial_word_source_if #(.WIDTH(W)) bus_l ();
  assign bus_m.din  = din_r;
  assign bus_m.load = load_r;
  assign bus_l.din  = din_r;
  assign bus_l.load = load_r;

  logic x_m, busy_m, last_m, st_m;
  logic x_l, busy_l, last_l, st_l;

  serial_word_source #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) u_msb (
    .CLK(clk), .CLR(clr), .bus(bus_m),
    .x(x_m), .busy(busy_m), .last(last_m), .dbg_state_o(st_m)
  );

  serial_word_source #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1)) u_lsb (
    .CLK(clk), .CLR(clr), .bus(bus_l),
    .x(x_l), .busy(busy_l), .last(last_l), .dbg_state_o(st_l)
  );

  // Each entry is {last, bit}; the queue holds every bit still to appear on x.
  logic [1:0] exp_m[$];
  logic [1:0] exp_l[$];
  int  checks = 0;
  int  errors = 0;
  bit  acc_flag = 1'b0;

  task automatic chk(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got=%b exp=%b", nm, $time, act, exp);
    end
  endtask

  // Reference: the source can take a word whenever fewer than one full word
  // of bits is still waiting behind the bit currently on the line.
  always @(posedge clk) begin
    acc_flag = 1'b0;
    if (!clr && load_r && exp_m.size() < W) begin
      acc_flag = 1'b1;
      for (int k = 0; k < W; k++) begin
        exp_m.push_back({(k == W - 1), din_r[W-1-k]});
        exp_l.push_back({(k == W - 1), din_r[k]});
      end
    end
  end

  logic [1:0] em, el;
  bit         hm, hl;
  always @(negedge clk) begin
    hm = (exp_m.size() > 0);
    em = hm ? exp_m.pop_front() : 2'b00;
    hl = (exp_l.size() > 0);
    el = hl ? exp_l.pop_front() : 2'b01;
    chk("busy_m", busy_m, hm);
    chk("x_m", x_m, em[0]);
    chk("last_m", last_m, em[1]);
    chk("ready_m", bus_m.ready, exp_m.size() < W);
    chk("busy_l", busy_l, hl);
    chk("x_l", x_l, el[0]);
    chk("last_l", last_l, el[1]);
    chk("ready_l", bus_l.ready, exp_l.size() < W);
  end

  task automatic send_word(input logic [W-1:0] w);
    bit taken;
    taken  = 1'b0;
    din_r  = w;
    load_r = 1'b1;
    for (int t = 0; t < 100 && !taken; t++) begin
      @(posedge clk);
      #1;
      taken = acc_flag;
    end
    checks++;
    if (!taken) begin
      errors++;
      $display("FAIL accept_timeout word=%h got=not_taken exp=taken", w);
    end
    load_r = 1'b0;
    din_r  = $urandom;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (exp_m.size() > 0 && t < 200) begin
      @(posedge clk);
      #1;
      t++;
    end
    checks++;
    if (exp_m.size() > 0) begin
      errors++;
      $display("FAIL drain_timeout got=%0d_bits_left exp=0", exp_m.size());
    end
    idle_cycles(2);
  endtask

  initial begin
    idle_cycles(2);
    chk("rst_x_m", x_m, 1'b0);
    chk("rst_x_l", x_l, 1'b1);
    chk("rst_busy", busy_m, 1'b0);
    chk("rst_last", last_m, 1'b0);
    chk("rst_ready", bus_m.ready, 1'b1);
    #1 clr = 1'b0;

    // Single word; the LSB instance sees the same word reversed.
    send_word(8'hA5);
    wait_drain();
    send_word(8'h01);
    wait_drain();

    // Second word accepted two cycles after the first: held, then contiguous.
    send_word(8'hA5);
    idle_cycles(1);
    send_word(8'h3C);
    wait_drain();

    // Backpressure: third word waits on a full holding register.
    send_word(8'hA5);
    send_word(8'h3C);
    send_word(8'hFF);
    wait_drain();

    // Reset during bit 4 of A5 while 3C is held.
    send_word(8'hA5);
    send_word(8'h3C);
    idle_cycles(3);
    #1;
    clr = 1'b1;
    exp_m.delete();
    exp_l.delete();
    #1;
    chk("clr_x_m", x_m, 1'b0);
    chk("clr_x_l", x_l, 1'b1);
    chk("clr_busy", busy_m, 1'b0);
    chk("clr_last", last_m, 1'b0);
    chk("clr_ready", bus_m.ready, 1'b1);
    idle_cycles(2);
    #1 clr = 1'b0;
    idle_cycles(6);

    // Detector pattern.
    send_word(8'b1100_1000);
    wait_drain();

    // Random words with random gaps, including zero-gap streaming.
    for (int n = 0; n < 40; n++) begin
      send_word(W'($urandom));
      idle_cycles($urandom_range(0, 3));
    end
    wait_drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
